// File: rtl/ballplayer_pkg.sv
// Shared types and constants for the ball-player blocks: screen geometry,
// row/velocity widths, hand-tracker FSM encoding and the distance clamp.
package ballplayer_pkg;

  localparam int MAX_Y = 309;
  localparam int ROW_W = 9;
  localparam int VEL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_WAIT = 3'd2,
    ST_FILT = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // Clamp a raw distance into [min_mm, min_mm+MAX_Y] and rebase it to a row.
  function automatic logic [ROW_W-1:0] clamp_row(input logic [11:0] mm, input int min_mm);
    int d;
    d = int'(mm);
    if (d < min_mm) begin
      return '0;
    end else if (d > min_mm + MAX_Y) begin
      return ROW_W'(MAX_Y);
    end else begin
      return ROW_W'(d - min_mm);
    end
  endfunction

endpackage

// File: rtl/hand_tracker_if.sv
// Link between the hand tracker and the range sensor: trigger pulse out,
// one distance sample back per frame.
//
// Handshake: a sample transfers on a rising clk edge where sample_valid and
// sample_ready are both high. sample_ready is driven by the tracker and is
// high only while it waits for a sample; sample_valid seen while sample_ready
// is low is ignored and nothing is latched.
interface hand_tracker_if;

  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        trigger;

  modport master (
    input  sample_data,
    input  sample_valid,
    output sample_ready,
    output trigger
  );

  modport slave (
    output sample_data,
    output sample_valid,
    input  sample_ready,
    input  trigger
  );

endinterface

// File: rtl/hand_avg4.sv
// Four-tap moving average of hand rows. The first sample after reset fills
// every tap so the output starts at the measured row instead of ramping.
module hand_avg4
  import ballplayer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             prefill,
  input  logic [ROW_W-1:0] din,
  output logic [ROW_W-1:0] avg
);

  logic [3:0][ROW_W-1:0] taps;
  logic [3:0][ROW_W-1:0] taps_n;
  logic [ROW_W+1:0]      sum_n;

  // avg is registered from the incoming taps so it is valid the cycle after load.
  always_comb begin
    taps_n = taps;
    if (load) begin
      if (prefill) begin
        taps_n = {4{din}};
      end else begin
        taps_n = {taps[2], taps[1], taps[0], din};
      end
    end
    sum_n = (ROW_W+2)'(taps_n[0]) + (ROW_W+2)'(taps_n[1])
          + (ROW_W+2)'(taps_n[2]) + (ROW_W+2)'(taps_n[3]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      taps <= '0;
      avg  <= '0;
    end else if (load) begin
      taps <= taps_n;
      avg  <= sum_n[ROW_W+1:2];
    end
  end

endmodule

// File: rtl/hand_tracker.sv
// Hand tracker: triggers the range sensor once per frame, takes one distance
// sample, filters it into a screen row and derives the downward hand speed.
module hand_tracker
  import ballplayer_pkg::*;
#(
  parameter int TICK_DIV    = 219089,
  parameter int TRIG_CYCLES = 120,
  parameter int TIMEOUT     = 200000,
  parameter int MIN_MM      = 50,
  parameter int VEL_SHIFT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  hand_tracker_if.master   sen,
  output logic [ROW_W-1:0] handline,
  output logic [VEL_W-1:0] hand_velocity,
  output logic             hand_valid,
  output state_e           fsm_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state, state_n;
  logic [TW-1:0]    tick_cnt;
  logic [GW-1:0]    trig_cnt;
  logic [WW-1:0]    wait_cnt;
  logic             tick;
  logic             accept;
  logic             timeout;
  logic [11:0]      sample_q;
  logic             first;
  logic             vel_zero;
  logic [ROW_W-1:0] prev_line;
  logic [ROW_W-1:0] avg;
  logic [ROW_W-1:0] row_in;
  logic [ROW_W-1:0] delta;
  logic [15:0]      shifted;
  logic [VEL_W-1:0] vel_sat;

  assign tick             = (tick_cnt == TW'(TICK_DIV - 1));
  assign accept           = (state == ST_WAIT) && sen.sample_valid;
  assign timeout          = (state == ST_WAIT) && !sen.sample_valid
                            && (wait_cnt == WW'(TIMEOUT - 1));
  assign sen.sample_ready = (state == ST_WAIT);
  assign sen.trigger      = (state == ST_TRIG);
  assign fsm_state        = state;
  assign row_in           = clamp_row(sample_q, MIN_MM);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (tick) state_n = ST_TRIG;
      ST_TRIG: if (trig_cnt == GW'(TRIG_CYCLES - 1)) state_n = ST_WAIT;
      ST_WAIT: begin
        if (accept) begin
          state_n = ST_FILT;
        end else if (timeout) begin
          state_n = ST_IDLE;
        end
      end
      ST_FILT: state_n = ST_OUT;
      ST_OUT:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Only downward motion (growing row) produces speed; the shift scales it.
  always_comb begin
    delta   = (avg > prev_line) ? (avg - prev_line) : '0;
    shifted = 16'(delta) << VEL_SHIFT;
    vel_sat = (shifted > 16'd255) ? 8'd255 : shifted[VEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      trig_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      trig_cnt <= (state == ST_TRIG) ? trig_cnt + GW'(1) : '0;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + WW'(1) : '0;
    end
  end

  // vel_zero remembers that the sample being output was the prefill one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_q      <= '0;
      first         <= 1'b1;
      vel_zero      <= 1'b0;
      prev_line     <= '0;
      handline      <= '0;
      hand_velocity <= '0;
      hand_valid    <= 1'b0;
    end else begin
      if (accept) begin
        sample_q <= sen.sample_data;
      end
      if (state == ST_FILT) begin
        vel_zero <= first;
        first    <= 1'b0;
      end
      if (timeout) begin
        hand_valid    <= 1'b0;
        hand_velocity <= '0;
      end
      if (state == ST_OUT) begin
        handline      <= avg;
        hand_velocity <= vel_zero ? '0 : vel_sat;
        hand_valid    <= 1'b1;
        prev_line     <= avg;
      end
    end
  end

  hand_avg4 u_avg (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ST_FILT),
    .prefill (first),
    .din     (row_in),
    .avg     (avg)
  );

endmodule
